iob_eth_tx_frontend: RTL and testbench
======================================

Name: iob_eth_tx_frontend

Overview:
TX front-end that sits directly downstream of the Ethernet DMA. It holds the frame buffer written word-by-word by the DMA. On a send command it serialises preamble, SFD, payload, optional CRC-32 FCS and inter-frame gap onto an MII-style nibble interface. It paces nibbles with a PHY clock-enable strobe, so the whole block runs on the single system clock.

Parameters:
BUFFER_W, 11, word-address width of the frame buffer (2^BUFFER_W x 32-bit words)
IFG_NIBBLES, 24, idle nibble strobes after each frame (12 bytes)

Ports:
clk_i  in  1  system clock
cke_i  in  1  global clock enable; when low, all state holds
arst_n_i  in  1  asynchronous active-low reset
eth_data_wr_wen_i  in  1  buffer word write enable
eth_data_wr_wstrb_i  in  4  byte write strobes
eth_data_wr_addr_i  in  BUFFER_W  buffer word address
eth_data_wr_wdata_i  in  32  write data; byte0 = bits[7:0]
send_i  in  1  start-frame pulse
tx_nbytes_i  in  11  payload length in bytes, excluding FCS
crc_en_i  in  1  append FCS
tx_ready_o  out  1  idle and able to accept send_i
tx_done_o  out  1  one-cycle pulse when the last frame nibble is driven
tx_clk_en_i  in  1  nibble strobe from PHY clock domain logic
mii_tx_en_o  out  1  MII transmit enable
mii_txd_o  out  4  MII transmit nibble

Behaviour:
- Clock and reset: one clock, clk_i. Reset is arst_n_i, asynchronous and active-low.
- Reset values: tx_ready_o=1, tx_done_o=0, mii_tx_en_o=0, mii_txd_o=0, FSM=IDLE, all counters 0. Buffer contents are undefined after reset.
- All sequential updates require cke_i=1.
- Buffer writes:
  - Accepted on any cycle, in any state.
  - Per-byte update governed by wstrb.
  - Writes during an active frame are allowed; it is software's duty not to overwrite live data.
- Byte read path: byte index k reads word k>>2, lane k[1:0]. Read latency is 1 cycle.
- Strobe rule: tx_clk_en_i is never high on two consecutive cycles. The block prefetches the next byte in the gap between strobes.
- FSM states: IDLE, PREAMBLE, SFD, DATA, FCS, IFG.
- IDLE:
  - send_i=1 latches tx_nbytes_i and crc_en_i, clears tx_ready_o next cycle and moves to PREAMBLE.
  - send_i while tx_ready_o=0 is ignored.
- Nibble output: mii_txd_o and mii_tx_en_o update only on cycles with tx_clk_en_i=1. The low nibble of each byte is sent first.
- PREAMBLE: 14 strobes of nibble 0x5 with tx_en=1.
- SFD: nibble 0x5 then 0xD.
  - Next state is DATA if nbytes>0.
  - Otherwise FCS if crc_en=1.
  - Otherwise IFG.
- DATA: 2*nbytes nibbles, byte index 0..nbytes-1.
- CRC:
  - Computed over payload bytes only, in DATA.
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - FCS = ~crc, sent as 8 nibbles LSB first.
- tx_done_o: pulses in the cycle the last DATA or FCS nibble is driven.
  - For nbytes=0 and crc_en=0, it pulses on the last SFD nibble.
- IFG:
  - mii_tx_en_o=0 and mii_txd_o=0 for IFG_NIBBLES strobes.
  - Then go to IDLE with tx_ready_o=1 in the cycle after the final IFG strobe.
- First nibble timing: the first PREAMBLE nibble appears on the first strobe at least 1 cycle after the cycle send_i is sampled.
- Widths:
  - Nibble counter is 12 bits, covering 2*2047.
  - Byte index is 11 bits.
  - The buffer must hold at least ceil(nbytes/4) words. Indices beyond the buffer wrap modulo 2^BUFFER_W words.
- Reset mid-frame: outputs immediately go to their reset values and the FSM returns to IDLE. No partial FCS is emitted.
- cke_i low: all state and outputs freeze. A strobe arriving on a cycle with cke_i=0 is lost.

Test Plan:
- Reset: hold arst_n_i=0 for 3 cycles with random inputs -> tx_ready_o=1, mii_tx_en_o=0, mii_txd_o=0, tx_done_o=0.
- CRC frame:
  - Stimulus: write words 0x34333231, 0x38373635, 0x00000039 ("123456789"); send_i with nbytes=9, crc_en=1; strobe every 4 cycles.
  - Required nibbles: 14x 5, then 5, D, then 1,3,2,3,...,9,3, then FCS bytes 26 39 F4 CB as nibbles 6,2,9,3,4,F,B,C.
  - Required control: tx_done_o pulses on nibble C; tx_ready_o returns after 24 idle strobes.
- No-CRC frame: nbytes=1, crc_en=0, word 0x000000A7 -> after SFD, nibbles 7, A; tx_en drops on the next strobe; tx_done_o pulses on A.
- Zero length: nbytes=0, crc_en=1 -> FCS is 0xFFFFFFFF inverted, i.e. 8 nibbles of 0 after SFD.
- Busy send and wstrb:
  - send_i asserted during DATA -> ignored; the frame is unchanged.
  - wstrb=0010 write of 0xFFFFFFFF onto 0x34333231 -> the frame carries bytes 31 FF 33 34.
- Reset mid-frame: deassert arst_n_i during DATA -> mii_tx_en_o=0 immediately; after release, tx_ready_o=1 and the next send transmits a correct full frame.

Source files
------------

// File: rtl/iob_eth_tx_frontend_if.sv
// DMA-side frame-buffer write port for the Ethernet TX front-end.
// master drives word writes; slave is the front-end buffer.
interface iob_eth_tx_frontend_if #(
  parameter int BUFFER_W = 11
);
  logic                wen;
  logic [3:0]          wstrb;
  logic [BUFFER_W-1:0] addr;
  logic [31:0]         wdata;

  modport master (
    output wen,
    output wstrb,
    output addr,
    output wdata
  );

  modport slave (
    input wen,
    input wstrb,
    input addr,
    input wdata
  );
endinterface

// File: rtl/iob_eth_tx_frontend.sv
// Ethernet TX front-end: frame buffer plus MII nibble serialiser
// (preamble, SFD, payload, optional CRC-32 FCS, inter-frame gap).
// Ports: clk_i/cke_i/arst_n_i; eth_data_wr buffer write bus;
// send_i/tx_nbytes_i/crc_en_i start a frame, tx_ready_o/tx_done_o
// report status; tx_clk_en_i paces mii_tx_en_o/mii_txd_o.
module iob_eth_tx_frontend #(
  parameter int BUFFER_W    = 11,
  parameter int IFG_NIBBLES = 24
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  arst_n_i,
  iob_eth_tx_frontend_if.slave  eth_data_wr,
  input  logic                  send_i,
  input  logic [10:0]           tx_nbytes_i,
  input  logic                  crc_en_i,
  output logic                  tx_ready_o,
  output logic                  tx_done_o,
  input  logic                  tx_clk_en_i,
  output logic                  mii_tx_en_o,
  output logic [3:0]            mii_txd_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_FCS,
    S_IFG
  } state_t;

  state_t r_state;

  logic [31:0]         r_mem [2**BUFFER_W];
  logic [31:0]         r_rword;
  logic [1:0]          r_lane;
  logic [10:0]         r_nbytes;
  logic                r_crc_en;
  logic [11:0]         r_cnt;
  logic [10:0]         r_bidx;
  logic [31:0]         r_crc;
  logic                r_ready;
  logic                r_done;
  logic                r_en;
  logic [3:0]          r_txd;

  logic [BUFFER_W-1:0] w_raddr;
  logic [7:0]          w_byte;
  logic [3:0]          w_data_nib;
  logic [31:0]         w_fcs;
  logic [3:0]          w_fcs_nib;
  logic                w_last;

  function automatic logic [31:0] f_crc8(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] x;
    x = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    end
    return x;
  endfunction

  always_ff @(posedge clk_i) begin
    if (cke_i && eth_data_wr.wen) begin
      for (int b = 0; b < 4; b++) begin
        if (eth_data_wr.wstrb[b]) begin
          r_mem[eth_data_wr.addr][8*b +: 8] <=
            eth_data_wr.wdata[8*b +: 8];
        end
      end
    end
  end

  // Byte at r_bidx is read continuously; strobes are at least two
  // cycles apart, so the prefetch settles before the next strobe.
  assign w_raddr = BUFFER_W'(r_bidx >> 2);

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      r_rword <= r_mem[w_raddr];
      r_lane  <= r_bidx[1:0];
    end
  end

  assign w_byte     = 8'(r_rword >> {r_lane, 3'b000});
  assign w_data_nib = r_cnt[0] ? w_byte[7:4] : w_byte[3:0];
  assign w_fcs      = ~r_crc;
  assign w_fcs_nib  = 4'(w_fcs >> {r_cnt[2:0], 2'b00});
  assign w_last     = (r_cnt == ({r_nbytes, 1'b0} - 12'd1));

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state  <= S_IDLE;
      r_nbytes <= '0;
      r_crc_en <= 1'b0;
      r_cnt    <= '0;
      r_bidx   <= '0;
      r_crc    <= '0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_en     <= 1'b0;
      r_txd    <= '0;
    end else if (cke_i) begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (send_i) begin
          r_nbytes <= tx_nbytes_i;
          r_crc_en <= crc_en_i;
          r_cnt    <= '0;
          r_bidx   <= '0;
          r_crc    <= 32'hFFFFFFFF;
          r_ready  <= 1'b0;
          r_state  <= S_PRE;
        end
      end else if (tx_clk_en_i) begin
        r_cnt <= r_cnt + 12'd1;
        case (r_state)
          S_PRE: begin
            r_en  <= 1'b1;
            r_txd <= 4'h5;
            if (r_cnt == 12'd13) begin
              r_cnt   <= '0;
              r_state <= S_SFD;
            end
          end
          S_SFD: begin
            r_en <= 1'b1;
            if (!r_cnt[0]) begin
              r_txd <= 4'h5;
            end else begin
              r_txd <= 4'hD;
              r_cnt <= '0;
              if (r_nbytes != '0) begin
                r_state <= S_DATA;
              end else if (r_crc_en) begin
                r_state <= S_FCS;
              end else begin
                r_done  <= 1'b1;
                r_state <= S_IFG;
              end
            end
          end
          S_DATA: begin
            r_en  <= 1'b1;
            r_txd <= w_data_nib;
            // Byte fully sent on its high nibble: fold into CRC, advance.
            if (r_cnt[0]) begin
              r_crc  <= f_crc8(r_crc, w_byte);
              r_bidx <= r_bidx + 11'd1;
            end
            if (w_last) begin
              r_cnt <= '0;
              if (r_crc_en) begin
                r_state <= S_FCS;
              end else begin
                r_done  <= 1'b1;
                r_state <= S_IFG;
              end
            end
          end
          S_FCS: begin
            r_en  <= 1'b1;
            r_txd <= w_fcs_nib;
            if (r_cnt == 12'd7) begin
              r_cnt   <= '0;
              r_done  <= 1'b1;
              r_state <= S_IFG;
            end
          end
          S_IFG: begin
            r_en  <= 1'b0;
            r_txd <= '0;
            if (r_cnt == 12'(IFG_NIBBLES - 1)) begin
              r_cnt   <= '0;
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign tx_ready_o  = r_ready;
  assign tx_done_o   = r_done;
  assign mii_tx_en_o = r_en;
  assign mii_txd_o   = r_txd;

endmodule

// File: tb/tb_iob_eth_tx_frontend.sv
// Directed bench for iob_eth_tx_frontend: nibble stream, done pulse,
// ready timing, wstrb, busy send and mid-frame reset.
module tb_iob_eth_tx_frontend;

  logic        clk = 1'b0;
  logic        cke;
  logic        arst_n;
  logic        send;
  logic [10:0] nbytes;
  logic        crc_en;
  logic        ready;
  logic        done;
  logic        stb;
  logic        tx_en;
  logic [3:0]  txd;

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  eb [16];

  iob_eth_tx_frontend_if #(.BUFFER_W(11)) wr_if ();

  iob_eth_tx_frontend #(
    .BUFFER_W   (11),
    .IFG_NIBBLES(24)
  ) dut (
    .clk_i       (clk),
    .cke_i       (cke),
    .arst_n_i    (arst_n),
    .eth_data_wr (wr_if),
    .send_i      (send),
    .tx_nbytes_i (nbytes),
    .crc_en_i    (crc_en),
    .tx_ready_o  (ready),
    .tx_done_o   (done),
    .tx_clk_en_i (stb),
    .mii_tx_en_o (tx_en),
    .mii_txd_o   (txd)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(
    input logic [10:0] a,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    @(negedge clk);
    wr_if.wen   = 1'b1;
    wr_if.addr  = a;
    wr_if.wdata = d;
    wr_if.wstrb = s;
    @(negedge clk);
    wr_if.wen   = 1'b0;
  endtask

  // One strobe; check {tx_en, txd, done} after the edge it drives.
  task automatic nib(
    input string    tag,
    input logic     e,
    input logic [3:0] d,
    input logic     dn
  );
    @(negedge clk);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    chk(tag, 32'({tx_en, txd, done}), 32'({e, d, dn}));
    @(negedge clk);
    if (dn) chk({tag, "_done_end"}, 32'(done), 32'd0);
    @(negedge clk);
  endtask

  task automatic do_send(input int nb, input logic c);
    @(negedge clk);
    send   = 1'b1;
    nbytes = 11'(nb);
    crc_en = c;
    @(negedge clk);
    send   = 1'b0;
    chk("ready_low", 32'(ready), 32'd0);
  endtask

  task automatic pre_sfd(input int nb, input logic c);
    for (int i = 0; i < 14; i++) nib("pre", 1'b1, 4'h5, 1'b0);
    nib("sfd5", 1'b1, 4'h5, 1'b0);
    nib("sfdD", 1'b1, 4'hD, (nb == 0) && !c);
  endtask

  task automatic rest_frame(
    input int          nb,
    input logic        c,
    input logic [31:0] fcs,
    input logic        poke
  );
    logic lastb;
    for (int i = 0; i < nb; i++) begin
      lastb = (i == nb - 1) && !c;
      nib($sformatf("d%0d_lo", i), 1'b1, eb[i][3:0], 1'b0);
      if (poke && i == 0) begin
        @(negedge clk);
        send   = 1'b1;
        nbytes = 11'd1;
        crc_en = 1'b1;
        @(negedge clk);
        send   = 1'b0;
        chk("busy_ready", 32'(ready), 32'd0);
      end
      nib($sformatf("d%0d_hi", i), 1'b1, eb[i][7:4], lastb);
    end
    if (c) begin
      for (int j = 0; j < 8; j++) begin
        nib($sformatf("fcs%0d", j), 1'b1, fcs[4*j +: 4], j == 7);
      end
    end
    for (int k = 0; k < 24; k++) begin
      nib("ifg", 1'b0, 4'h0, 1'b0);
      chk($sformatf("ifg_ready%0d", k), 32'(ready), 32'(k == 23));
    end
  endtask

  task automatic frame(
    input int          nb,
    input logic        c,
    input logic [31:0] fcs,
    input logic        poke
  );
    do_send(nb, c);
    pre_sfd(nb, c);
    rest_frame(nb, c, fcs, poke);
  endtask

  task automatic load_123456789();
    wr(11'd0, 32'h34333231, 4'hF);
    wr(11'd1, 32'h38373635, 4'hF);
    wr(11'd2, 32'h00000039, 4'hF);
    for (int i = 0; i < 9; i++) eb[i] = 8'(8'h31 + i);
  endtask

  initial begin
    arst_n      = 1'b0;
    cke         = 1'b1;
    send        = 1'b0;
    nbytes      = '0;
    crc_en      = 1'b0;
    stb         = 1'b0;
    wr_if.wen   = 1'b0;
    wr_if.wstrb = '0;
    wr_if.addr  = '0;
    wr_if.wdata = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cke    = 1'($urandom);
      send   = 1'($urandom);
      nbytes = 11'($urandom);
      crc_en = 1'($urandom);
      stb    = 1'($urandom);
    end
    chk("rst_outs", 32'({ready, done, tx_en, txd}), 32'h40);
    @(negedge clk);
    cke    = 1'b1;
    send   = 1'b0;
    stb    = 1'b0;
    arst_n = 1'b1;
    @(negedge clk);
    chk("post_rst", 32'({ready, done, tx_en, txd}), 32'h40);

    load_123456789();
    frame(9, 1'b1, 32'hCBF43926, 1'b0);

    wr(11'd0, 32'h000000A7, 4'hF);
    eb[0] = 8'hA7;
    frame(1, 1'b0, 32'h0, 1'b0);

    frame(0, 1'b1, 32'h0, 1'b0);

    wr(11'd0, 32'h34333231, 4'hF);
    wr(11'd0, 32'hFFFFFFFF, 4'b0010);
    eb[0] = 8'h31;
    eb[1] = 8'hFF;
    eb[2] = 8'h33;
    eb[3] = 8'h34;
    frame(4, 1'b0, 32'h0, 1'b1);

    load_123456789();
    do_send(9, 1'b1);
    pre_sfd(9, 1'b1);
    nib("mid_lo", 1'b1, 4'h1, 1'b0);
    nib("mid_hi", 1'b1, 4'h3, 1'b0);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk("mid_rst", 32'({ready, done, tx_en, txd}), 32'h40);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    chk("mid_ready", 32'(ready), 32'd1);
    frame(9, 1'b1, 32'hCBF43926, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
